// File: rtl/hilo_unit.sv
// HI/LO result registers fed by an external shift-add multiplier: magnitudes in, sign fixed on the way back.
// start -> LOAD next cycle -> WAIT until mul_dne (ignored in the first WAIT cycle) or TIMEOUT; start while busy is dropped.
module hilo_unit #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sgn,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_ena,
  output logic        mul_rst,
  input  logic [63:0] mul_p,
  input  logic        mul_dne
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, WAIT = 2'd2} state_t;

  state_t      state_q;
  logic [31:0] hi_q, lo_q, mul_a_q, mul_b_q;
  logic        busy_q, done_q, err_q, ena_q, mrst_q, neg_q;
  logic [CW-1:0] cnt_q;

  logic [31:0] mag_a_d, mag_b_d;
  logic [63:0] res_d;
  logic        dne_ok_d, tmo_d;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign mag_a_d  = (sgn && op_a[31]) ? (~op_a + 32'd1) : op_a;
  assign mag_b_d  = (sgn && op_b[31]) ? (~op_b + 32'd1) : op_b;
  assign res_d    = neg_q ? (~mul_p + 64'd1) : mul_p;
  assign dne_ok_d = (cnt_q != '0) && mul_dne;
  assign tmo_d    = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ena_q   <= 1'b0;
      mrst_q  <= 1'b0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mul_a_q <= mag_a_d;
            mul_b_q <= mag_b_d;
            neg_q   <= sgn & (op_a[31] ^ op_b[31]);
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            ena_q   <= 1'b1;
            mrst_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= LOAD;
          end else begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
          end
        end
        LOAD: begin
          mrst_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // cnt_q holds the number of WAIT cycles already elapsed.
          if (dne_ok_d) begin
            {hi_q, lo_q} <= res_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ena_q   <= 1'b0;
            state_q <= IDLE;
          end else if (tmo_d) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            ena_q   <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          ena_q   <= 1'b0;
          mrst_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign hi      = hi_q;
  assign lo      = lo_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign mul_a   = mul_a_q;
  assign mul_b   = mul_b_q;
  assign mul_ena = ena_q;
  assign mul_rst = mrst_q;

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 Parameter TIMEOUT, default 40: maximum cycles in WAIT before abort.
REQ-002 clk  in  1  single clock; all state changes on posedge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 start  in  1  request a multiply; sampled only in IDLE.
REQ-005 sgn  in  1  with start: 1 = signed (two's complement), 0 = unsigned.
REQ-006 op_a, op_b  in  32 each  operands, sampled with start.
REQ-007 hi_we, lo_we  in  1 each  direct write of wdata into HI / LO.
REQ-008 wdata  in  32  write data for hi_we/lo_we.
REQ-009 hi, lo  out  32 each  HI/LO result registers.
REQ-010 busy  out  1  high from the cycle after start is accepted until the op completes or aborts.
REQ-011 done  out  1  one-cycle pulse when HI/LO are updated by a multiply.
REQ-012 err  out  1  sticky timeout flag; cleared by the next accepted start.
REQ-013 mul_a, mul_b  out  32 each  magnitude operands to the shift-add multiplier.
REQ-014 mul_ena, mul_rst  out  1 each  multiplier enable and synchronous load strobe.
REQ-015 mul_p  in  64  multiplier product.
REQ-016 mul_dne  in  1  multiplier done.

Function
REQ-017 FSM states: IDLE, LOAD, WAIT. No other states.
REQ-018 IDLE, start=1: capture magnitudes |op_a| and |op_b| (or the raw values if sgn=0) into mul_a and mul_b; latch neg = sgn & (op_a[31]^op_b[31]); clear err; go to LOAD.
REQ-019 The magnitude of 0x80000000 is 0x80000000, which is 32-bit unsigned with no overflow.
REQ-020 LOAD: mul_ena=1, mul_rst=1 for exactly one cycle; go to WAIT.
REQ-021 WAIT: mul_ena=1, mul_rst=0; ignore mul_dne in the first WAIT cycle, because the multiplier's done flag clears at the LOAD edge.
REQ-022 WAIT, from the second cycle, mul_dne=1: HI:LO <= neg ? (~mul_p + 1) : mul_p, computed mod 2^64; pulse done; go to IDLE.
REQ-023 WAIT cycle count reaching TIMEOUT with no mul_dne: set err=1; leave HI/LO unchanged; no done pulse; go to IDLE.
REQ-024 mul_ena=0 and mul_rst=0 in IDLE; mul_a and mul_b hold their last values.
REQ-025 busy=1 exactly while state is LOAD or WAIT.
REQ-026 start while busy is ignored, with no queueing.
REQ-027 hi_we/lo_we in IDLE without start: write wdata on the next edge; hi_we and lo_we in the same cycle write both registers.
REQ-028 hi_we/lo_we while busy, or in the same cycle as an accepted start, are dropped.
REQ-029 Latency: start at edge N is followed by LOAD in cycle N+1, and WAIT from N+2. Done asserts the cycle after the first valid mul_dne. Worst case with the 32-bit shift-add multiplier is at most 36 cycles from start to done.
REQ-030 Unsigned op: HI:LO equals the full 64-bit unsigned product of op_a and op_b.

Reset
REQ-031 When rst is asserted, asynchronously and at any time including mid-operation: state=IDLE; hi=0, lo=0, busy=0, done=0, err=0, mul_ena=0, mul_rst=0, mul_a=0, mul_b=0, neg=0, timeout counter=0.
REQ-032 An operation in flight when rst is asserted is discarded; no done pulse follows reset release.
REQ-033 The first start after rst deassertion is accepted normally.

Verification
REQ-034 Unsigned, op_a=3, op_b=5 -> one done pulse; hi=0x00000000, lo=0x0000000F; busy low the cycle after done.
REQ-035 Signed, op_a=0xFFFFFFFE, op_b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA. Signed, 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-036 Unsigned, 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Unsigned, op_a=0, op_b=7 -> done within 5 cycles of start; hi=0, lo=0.
REQ-037 Contention cases:
- Second start, and hi_we with wdata=0xDEAD, both issued mid-operation -> both ignored; HI/LO hold the first result.
- hi_we with wdata=0x1234 in IDLE -> hi=0x1234, lo unchanged.
REQ-038 Bench model holds mul_dne=0 -> err=1 after 40 WAIT cycles; HI/LO unchanged; no done. The next start clears err.
REQ-039 rst asserted in WAIT -> all outputs zero in the same cycle; no done pulse after release; a following 3x5 op completes with lo=15.
